// File: rtl/program_loader.sv
// Streams a big-endian byte image into CPU instruction memory one word at a time,
// holding the CPU in reset-like hold (cpu_run=0) until the whole image has landed.
//
// state | meaning
// IDLE  | waiting for start after reset; CPU held
// RECV  | accepting bytes of the current word
// WRITE | one-cycle instruction memory write of the assembled word
// DONE  | image complete; CPU released, new start reloads from index 0
module program_loader #(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(INSTR_MEM_SIZE);

    state_t              state;
    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] wcnt;
    logic [1:0]          bcnt;
    logic [23:0]         word;   // first three bytes; the fourth goes straight to imem_wdata
    logic                len_ok;

    assign len_ok = (length != '0) && (length <= MAX_LEN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            word       <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_run    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            state      <= RECV;
                            len_q      <= length;
                            wcnt       <= '0;
                            bcnt       <= '0;
                            error      <= 1'b0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            cpu_run    <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_valid && byte_ready) begin
                        word <= {word[15:0], byte_data};
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= wcnt[ADDR_WIDTH-1:0];
                            imem_wdata <= {word, byte_data};
                        end
                    end
                end
                WRITE: begin
                    imem_we <= 1'b0;
                    wcnt    <= wcnt + 1'b1;
                    bcnt    <= '0;
                    if (wcnt + 1'b1 == len_q) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
